mux_arbiter_l2: RTL and testbench
=================================

Name: mux_arbiter_l2

Overview:
- Round-robin arbiter and scheduler for the lane-2 2:1 byte mux path in the PHY, clocked on clk_4f.
- Each of two byte-wide requesters feeds its own small synchronous FIFO.
- The arbiter picks one non-empty FIFO per cycle and drives a registered byte and valid downstream under a valid/ready handshake.
- Per-lane almost-full pause outputs throttle the upstream stages; sticky overflow flags report dropped bytes.

Parameters:
- DATA_W, 8, byte width of every data bus
- FIFO_DEPTH, 4, entries per lane FIFO (power of two, >= 2)
- ALMOST_FULL, 3, occupancy at or above which pausaN asserts (1..FIFO_DEPTH)

Ports:
- clk_4f  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- Entrada0  in  DATA_W  lane 0 byte
- validEntrada0  in  1  lane 0 byte valid (push request)
- Entrada1  in  DATA_W  lane 1 byte
- validEntrada1  in  1  lane 1 byte valid (push request)
- ready  in  1  downstream accepts Salida this cycle
- Salida  out  DATA_W  arbitrated byte (registered)
- validsalida  out  1  Salida holds a valid byte (registered)
- sel  out  1  lane that sourced the current Salida
- pausa0  out  1  lane 0 FIFO at or above ALMOST_FULL
- pausa1  out  1  lane 1 FIFO at or above ALMOST_FULL
- err0  out  1  sticky: lane 0 byte dropped on full
- err1  out  1  sticky: lane 1 byte dropped on full

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFOs empty; Salida=0, validsalida=0, sel=0, pausa0/1=0, err0/1=0.
  - Round-robin pointer last=1, so lane 0 wins the first contention.
- Push: validEntradaN=1 writes EntradaN into FIFO N when count<FIFO_DEPTH, or when the FIFO is full and is popped in the same cycle.
- Overflow: a push when full with no pop is dropped and sets errN=1; errN clears only on reset.
- Output load condition: load = (!validsalida || ready).
- Pop and grant, evaluated only when load=1, using counts at the start of the cycle:
  - Neither FIFO non-empty: validsalida<=0; Salida and sel hold.
  - Exactly one FIFO non-empty: grant that lane.
  - Both non-empty: grant the lane != last.
  - On a grant: pop the head, Salida<=head, validsalida<=1, sel<=lane, last<=lane.
- Stall: validsalida=1 and ready=0 holds Salida, sel, validsalida and last stable; no pop occurs.
- No bypass. A byte pushed into an empty FIFO at edge N can appear on Salida at edge N+1 at the earliest (1-cycle latency).
- Throughput: one byte per cycle while ready=1 and data is available; both lanes backlogged gives strict alternation 0,1,0,1...
- pausaN = (countN >= ALMOST_FULL), combinational from the count register.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH) bits with natural wrap; count is log2(FIFO_DEPTH)+1 bits.
- Reset asserted mid-operation empties both FIFOs and discards any pending output immediately.

Optional Feature:
- Macro: MUX_ARB_FIXED_PRIORITY_EN.
- Defined: lane 0 has strict priority; lane 1 is granted only when FIFO 0 is empty. The last register is not implemented, and starvation of lane 1 is allowed.
- Undefined (default): round-robin as above.

Decomposition:
- Shared package/include (mux_arb_defs) holds:
  - DATA_W and FIFO_DEPTH defaults
  - lane ID constants LANE0=1'b0 and LANE1=1'b1
  - the pointer-width function/constant
- Natural sub-module: fifo_lane, a synchronous FIFO instantiated twice.
  - Inputs: clk_4f, reset, push, pop, din.
  - Outputs: dout, count, full, empty.
- Arbitration, output register and error flags stay in the top module.

Test Plan:
- Reset: hold reset=0 with inputs toggling -> all outputs 0. Release, push lane0 0xA5 -> Salida=0xA5, validsalida=1, sel=0 one edge after the push.
- Both lanes backlogged: push 0x10,0x11 on lane 0 and 0x20,0x21 on lane 1 in the same cycles, ready=1 -> output sequence 0x10,0x20,0x11,0x21 with sel 0,1,0,1.
- Stall: validsalida=1 with Salida=0x33, ready=0 for 3 cycles -> Salida, sel and validsalida unchanged, no FIFO pop. ready=1 -> next byte on the following edge.
- Full/overflow: ready=0, 5 pushes 0x01..0x05 on lane 1 -> pausa1=1 after the 3rd push and err1=1 after the 5th. With ready=1, 0x01..0x04 drain in order and 0x05 never appears.
- Full with simultaneous push/pop: FIFO 0 full, ready=1 so lane 0 is popped, push 0x77 on lane 0 in that same cycle -> push accepted, err0 stays 0, 0x77 drains last.
- Mid-operation reset: FIFOs partially full, assert reset=0 asynchronously between edges -> validsalida=0 immediately. After release, no stale bytes appear.

Source files
------------

// File: rtl/mux_arb_defs.sv
// Shared constants for the lane-2 2:1 byte mux arbiter: bus/FIFO defaults,
// lane identifiers and the FIFO pointer-width helper.
package mux_arb_defs;

    localparam int DATA_W_DEF      = 8;
    localparam int FIFO_DEPTH_DEF  = 4;
    localparam int ALMOST_FULL_DEF = 3;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    // Read/write pointer width; a depth of 1 still needs one pointer bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_lane.sv
// Per-lane synchronous FIFO: head is visible on dout, and a push while full
// is accepted only when the same cycle also pops.
module fifo_lane
    import mux_arb_defs::*;
#(
    parameter  int DATA_W     = DATA_W_DEF,
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int PTR_W      = ptr_w(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              full_s;
    logic              empty_s;
    logic              wr_en_s;
    logic              rd_en_s;

    assign full_s  = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty_s = (count_r == {CNT_W{1'b0}});
    assign wr_en_s = push && (!full_s || pop);
    assign rd_en_s = pop && !empty_s;

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;

    // Pointer and occupancy tracking; pointers wrap naturally.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array, cleared on reset so the head never shows stale data.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/mux_arbiter_l2.sv
// Lane-2 2:1 byte mux: two lane FIFOs, round-robin grant into a registered
// valid/ready output. Define MUX_ARB_FIXED_PRIORITY_EN for strict lane-0 priority.
module mux_arbiter_l2
    import mux_arb_defs::*;
#(
    parameter  int DATA_W      = DATA_W_DEF,
    parameter  int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter  int ALMOST_FULL = ALMOST_FULL_DEF,
    localparam int CNT_W       = ptr_w(FIFO_DEPTH) + 1
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic [DATA_W-1:0] Entrada0,
    input  logic              validEntrada0,
    input  logic [DATA_W-1:0] Entrada1,
    input  logic              validEntrada1,
    input  logic              ready,
    output logic [DATA_W-1:0] Salida,
    output logic              validsalida,
    output logic              sel,
    output logic              pausa0,
    output logic              pausa1,
    output logic              err0,
    output logic              err1
);

    logic [DATA_W-1:0] dout0_s;
    logic [DATA_W-1:0] dout1_s;
    logic [CNT_W-1:0]  count0_s;
    logic [CNT_W-1:0]  count1_s;
    logic              full0_s;
    logic              full1_s;
    logic              empty0_s;
    logic              empty1_s;
    logic              load_s;
    logic              grant_s;
    logic              grant_lane_s;
    logic              pop0_s;
    logic              pop1_s;

    logic [DATA_W-1:0] salida_r;
    logic              valid_r;
    logic              sel_r;
    logic              err0_r;
    logic              err1_r;
`ifndef MUX_ARB_FIXED_PRIORITY_EN
    logic              last_r;
`endif

    fifo_lane #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk_4f (clk_4f),
        .reset  (reset),
        .push   (validEntrada0),
        .pop    (pop0_s),
        .din    (Entrada0),
        .dout   (dout0_s),
        .count  (count0_s),
        .full   (full0_s),
        .empty  (empty0_s)
    );

    fifo_lane #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk_4f (clk_4f),
        .reset  (reset),
        .push   (validEntrada1),
        .pop    (pop1_s),
        .din    (Entrada1),
        .dout   (dout1_s),
        .count  (count1_s),
        .full   (full1_s),
        .empty  (empty1_s)
    );

    assign load_s = !valid_r || ready;
    assign pop0_s = grant_s && (grant_lane_s == LANE0);
    assign pop1_s = grant_s && (grant_lane_s == LANE1);

    // Grant selection from start-of-cycle occupancy; nothing moves while stalled.
    always_comb begin
        grant_s      = 1'b0;
        grant_lane_s = LANE0;
        if (load_s) begin
            case ({!empty1_s, !empty0_s})
                2'b01: begin
                    grant_s      = 1'b1;
                    grant_lane_s = LANE0;
                end
                2'b10: begin
                    grant_s      = 1'b1;
                    grant_lane_s = LANE1;
                end
                2'b11: begin
                    grant_s      = 1'b1;
`ifdef MUX_ARB_FIXED_PRIORITY_EN
                    grant_lane_s = LANE0;
`else
                    grant_lane_s = (last_r == LANE0) ? LANE1 : LANE0;
`endif
                end
                default: begin
                    grant_s      = 1'b0;
                    grant_lane_s = LANE0;
                end
            endcase
        end else begin
            grant_s      = 1'b0;
            grant_lane_s = LANE0;
        end
    end

    // Output register: load a granted head, or drop valid when both lanes are empty.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            salida_r <= {DATA_W{1'b0}};
            valid_r  <= 1'b0;
            sel_r    <= LANE0;
        end else if (load_s) begin
            if (grant_s) begin
                salida_r <= (grant_lane_s == LANE1) ? dout1_s : dout0_s;
                valid_r  <= 1'b1;
                sel_r    <= grant_lane_s;
            end else begin
                valid_r  <= 1'b0;
            end
        end
    end

`ifndef MUX_ARB_FIXED_PRIORITY_EN
    // Round-robin memory; reset to lane 1 so lane 0 wins the first contention.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            last_r <= LANE1;
        end else if (grant_s) begin
            last_r <= grant_lane_s;
        end
    end
`endif

    // Sticky overflow flags: a push into a full FIFO that is not popped is lost.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            err0_r <= 1'b0;
            err1_r <= 1'b0;
        end else begin
            err0_r <= err0_r | (validEntrada0 && full0_s && !pop0_s);
            err1_r <= err1_r | (validEntrada1 && full1_s && !pop1_s);
        end
    end

    assign Salida      = salida_r;
    assign validsalida = valid_r;
    assign sel         = sel_r;
    assign err0        = err0_r;
    assign err1        = err1_r;
    assign pausa0      = (count0_s >= CNT_W'(ALMOST_FULL));
    assign pausa1      = (count1_s >= CNT_W'(ALMOST_FULL));

endmodule

// File: tb/tb_mux_arbiter_l2.sv
// Scoreboard bench for mux_arbiter_l2: directed stimulus pushes expected
// {sel, byte} pairs; a negedge monitor checks every accepted output.
module tb_mux_arbiter_l2;

    logic       clk_4f = 1'b0;
    logic       reset  = 1'b0;
    logic [7:0] Entrada0 = 8'h00;
    logic       validEntrada0 = 1'b0;
    logic [7:0] Entrada1 = 8'h00;
    logic       validEntrada1 = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] Salida;
    logic       validsalida;
    logic       sel;
    logic       pausa0;
    logic       pausa1;
    logic       err0;
    logic       err1;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] exp_q [$];

    mux_arbiter_l2 dut (
        .clk_4f        (clk_4f),
        .reset         (reset),
        .Entrada0      (Entrada0),
        .validEntrada0 (validEntrada0),
        .Entrada1      (Entrada1),
        .validEntrada1 (validEntrada1),
        .ready         (ready),
        .Salida        (Salida),
        .validsalida   (validsalida),
        .sel           (sel),
        .pausa0        (pausa0),
        .pausa1        (pausa1),
        .err0          (err0),
        .err1          (err1)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every byte accepted downstream must match the scoreboard head.
    always @(negedge clk_4f) begin
        if (reset && validsalida && ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got Salida=0x%0h sel=%0d, expected no output", Salida, sel);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("out_byte", {24'h0, Salida}, {24'h0, e[7:0]});
                check("out_sel", {31'h0, sel}, {31'h0, e[8]});
            end
        end
    end

    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < max_cycles) begin
            tick();
            c++;
        end
        check({"drain_", name}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        // Reset held with toggling inputs: every output stays low.
        for (int i = 0; i < 4; i++) begin
            Entrada0      = 8'($urandom);
            Entrada1      = 8'($urandom);
            validEntrada0 = 1'b1;
            validEntrada1 = i[0];
            ready         = ~i[0];
            tick();
            check("reset_outputs", {18'h0, Salida, validsalida, sel, pausa0, pausa1, err0, err1}, 32'h0);
        end
        validEntrada0 = 1'b0;
        validEntrada1 = 1'b0;
        reset = 1'b1;
        ready = 1'b1;

        // First byte: one-edge latency, no bypass.
        Entrada0 = 8'hA5; validEntrada0 = 1'b1; exp_q.push_back({1'b0, 8'hA5});
        tick();
        validEntrada0 = 1'b0;
        check("no_bypass_valid", {31'h0, validsalida}, 32'h0);
        tick();
        check("first_valid", {31'h0, validsalida}, 32'h1);
        check("first_byte", {24'h0, Salida}, 32'hA5);
        wait_drain("first", 10);

        // Both lanes backlogged: strict alternation starting at lane 0.
        pulse_reset();
        ready = 1'b1;
        Entrada0 = 8'h10; Entrada1 = 8'h20; validEntrada0 = 1'b1; validEntrada1 = 1'b1;
        exp_q.push_back({1'b0, 8'h10});
        exp_q.push_back({1'b1, 8'h20});
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h21});
        tick();
        Entrada0 = 8'h11; Entrada1 = 8'h21;
        tick();
        validEntrada0 = 1'b0; validEntrada1 = 1'b0;
        wait_drain("alternate", 12);

        // Stall: output held stable while ready is low.
        ready = 1'b0;
        Entrada0 = 8'h33; validEntrada0 = 1'b1; exp_q.push_back({1'b0, 8'h33});
        tick();
        Entrada0 = 8'h44; exp_q.push_back({1'b0, 8'h44});
        tick();
        validEntrada0 = 1'b0;
        check("stall_loaded", {23'h0, validsalida, Salida}, {23'h0, 1'b1, 8'h33});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", {22'h0, validsalida, sel, Salida}, {22'h0, 1'b1, 1'b0, 8'h33});
        end
        ready = 1'b1;
        tick();
        check("stall_release_next", {23'h0, validsalida, Salida}, {23'h0, 1'b1, 8'h44});
        wait_drain("stall", 10);

        // Overflow on lane 1 behind a stalled output.
        ready = 1'b0;
        Entrada0 = 8'h55; validEntrada0 = 1'b1; exp_q.push_back({1'b0, 8'h55});
        tick();
        validEntrada0 = 1'b0;
        tick();
        for (int i = 1; i <= 5; i++) begin
            Entrada1 = 8'(i); validEntrada1 = 1'b1;
            if (i <= 4) exp_q.push_back({1'b1, 8'(i)});
            tick();
            if (i == 2) check("pausa1_below", {31'h0, pausa1}, 32'h0);
            if (i == 3) check("pausa1_at_thresh", {31'h0, pausa1}, 32'h1);
            if (i == 4) check("err1_full_no_drop", {31'h0, err1}, 32'h0);
            if (i == 5) check("err1_overflow", {31'h0, err1}, 32'h1);
        end
        validEntrada1 = 1'b0;
        check("pausa0_idle", {31'h0, pausa0}, 32'h0);
        ready = 1'b1;
        wait_drain("overflow", 12);
        check("err1_sticky", {31'h0, err1}, 32'h1);
        check("pausa1_drained", {31'h0, pausa1}, 32'h0);

        // Full lane 0 with a push in the same cycle as its pop.
        ready = 1'b0;
        Entrada0 = 8'h60; validEntrada0 = 1'b1; exp_q.push_back({1'b0, 8'h60});
        tick();
        validEntrada0 = 1'b0;
        tick();
        for (int i = 1; i <= 4; i++) begin
            Entrada0 = 8'h60 + 8'(i); validEntrada0 = 1'b1;
            exp_q.push_back({1'b0, 8'h60 + 8'(i)});
            tick();
        end
        check("pausa0_full", {31'h0, pausa0}, 32'h1);
        ready = 1'b1;
        Entrada0 = 8'h77; exp_q.push_back({1'b0, 8'h77});
        tick();
        validEntrada0 = 1'b0;
        check("err0_push_pop", {31'h0, err0}, 32'h0);
        wait_drain("full_push_pop", 12);
        check("err0_after_drain", {31'h0, err0}, 32'h0);

        // Asynchronous reset between edges discards everything.
        ready = 1'b0;
        Entrada0 = 8'h81; Entrada1 = 8'h91; validEntrada0 = 1'b1; validEntrada1 = 1'b1;
        tick();
        Entrada0 = 8'h82; Entrada1 = 8'h92;
        tick();
        validEntrada0 = 1'b0; validEntrada1 = 1'b0;
        check("pre_reset_valid", {31'h0, validsalida}, 32'h1);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {18'h0, Salida, validsalida, sel, pausa0, pausa1, err0, err1}, 32'h0);
        tick();
        reset = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_stale_bytes", {31'h0, validsalida}, 32'h0);
        end
        Entrada1 = 8'hC3; validEntrada1 = 1'b1; exp_q.push_back({1'b1, 8'hC3});
        tick();
        validEntrada1 = 1'b0;
        wait_drain("post_reset", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
